// File: rtl/sensor_array_filter_if.sv
// sensor_array_filter_if
//   Groups the sensor-side inputs and filtered outputs of sensor_array_filter.
//   master: drives X/POL/MASK/CNT_CLR and observes Z/RISE/ANY/EVT_CNT.
//   slave : the filter itself.
// Signals
//   X        raw sensor inputs (NCH)
//   POL      1: channel active when X=0, 0: active when X=1
//   MASK     1 removes the channel from ANY only (NCH)
//   CNT_CLR  synchronous clear of the event counters
//   Z        filtered channel state (NCH)
//   RISE     one-cycle pulse on Z 0->1 (NCH)
//   ANY      |(Z & ~MASK)
//   EVT_CNT  per-channel event counters, ch i at [i*CNT_W +: CNT_W]
interface sensor_array_filter_if #(
    parameter int NCH   = 4,
    parameter int CNT_W = 8
);
    logic [NCH-1:0]       X;
    logic                 POL;
    logic [NCH-1:0]       MASK;
    logic                 CNT_CLR;
    logic [NCH-1:0]       Z;
    logic [NCH-1:0]       RISE;
    logic                 ANY;
    logic [NCH*CNT_W-1:0] EVT_CNT;

    modport master (output X, POL, MASK, CNT_CLR, input Z, RISE, ANY, EVT_CNT);
    modport slave  (input X, POL, MASK, CNT_CLR, output Z, RISE, ANY, EVT_CNT);
endinterface

// File: rtl/sensor_array_filter.sv
// sensor_array_filter
//   NCH independent sensor channels, each with a persistence filter of DB_CYCLES
//   consecutive qualifying samples, selectable active polarity, a rise pulse,
//   a maskable OR alarm and optional saturating event counters.
// Build option
//   SENSOR_EVENT_CNT_EN : when defined, each channel keeps a CNT_W-bit saturating
//                         count of its rise events; otherwise EVT_CNT reads 0 and
//                         CNT_CLR is ignored.
// Ports
//   CLK  in  clock, all state on posedge
//   MR   in  master reset, synchronous, active-low
//   bus  sensor_array_filter_if.slave (X, POL, MASK, CNT_CLR in; Z, RISE, ANY, EVT_CNT out)

// One channel: debounce FSM, registered Z/RISE, optional event counter.
module sensor_array_filter_lane #(
    parameter int DB_CYCLES = 3,
    parameter int CNT_W     = 8
) (
    input  logic             CLK,
    input  logic             MR,
    input  logic             act,
    input  logic             cnt_clr,
    output logic             z,
    output logic             rise,
    output logic [CNT_W-1:0] evt_cnt
);
    localparam int            CW       = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PEND_ON, ACTIVE, PEND_OFF} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          go_on;
    logic          go_off;

    // Qualifying sample that completes a run; with DB_CYCLES==1 the very first
    // qualifying sample completes it, so the PEND states are never entered.
    always_comb begin
        go_on  = 1'b0;
        go_off = 1'b0;
        case (state)
            IDLE:     go_on  =  act && (DB_CYCLES == 1);
            PEND_ON:  go_on  =  act && (cnt == CNT_LAST);
            ACTIVE:   go_off = !act && (DB_CYCLES == 1);
            PEND_OFF: go_off = !act && (cnt == CNT_LAST);
            default:  ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!MR) begin
            state <= IDLE;
            cnt   <= '0;
            z     <= 1'b0;
            rise  <= 1'b0;
        end else begin
            rise <= go_on;
            if (go_on) begin
                state <= ACTIVE;
                cnt   <= '0;
                z     <= 1'b1;
            end else if (go_off) begin
                state <= IDLE;
                cnt   <= '0;
                z     <= 1'b0;
            end else begin
                case (state)
                    IDLE:     if (act) begin state <= PEND_ON; cnt <= CNT_ONE; end
                    PEND_ON:  if (act) cnt <= cnt + CNT_ONE;
                              else begin state <= IDLE; cnt <= '0; end
                    ACTIVE:   if (!act) begin state <= PEND_OFF; cnt <= CNT_ONE; end
                    PEND_OFF: if (!act) cnt <= cnt + CNT_ONE;
                              else begin state <= ACTIVE; cnt <= '0; end
                    default:  begin state <= IDLE; cnt <= '0; z <= 1'b0; end
                endcase
            end
        end
    end

`ifdef SENSOR_EVENT_CNT_EN
    // Counts on the same edge that sets RISE; a clear coinciding with a rise
    // leaves the new event counted.
    always_ff @(posedge CLK) begin
        if (!MR)
            evt_cnt <= '0;
        else if (cnt_clr)
            evt_cnt <= go_on ? CNT_W'(1) : '0;
        else if (go_on && (evt_cnt != '1))
            evt_cnt <= evt_cnt + CNT_W'(1);
    end
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign evt_cnt        = '0;
`endif
endmodule

module sensor_array_filter #(
    parameter int NCH       = 4,
    parameter int DB_CYCLES = 3,
    parameter int CNT_W     = 8
) (
    input logic                  CLK,
    input logic                  MR,
    sensor_array_filter_if.slave bus
);
    logic [NCH-1:0]            act;
    logic [NCH-1:0]            z;
    logic [NCH-1:0]            rise;
    logic [NCH-1:0][CNT_W-1:0] evt;

    // Polarity is applied per sample, so a POL change only alters what the
    // filters see next; no filter state is disturbed.
    assign act = bus.POL ? ~bus.X : bus.X;

    genvar i;
    generate
        for (i = 0; i < NCH; i++) begin : g_ch
            sensor_array_filter_lane #(
                .DB_CYCLES (DB_CYCLES),
                .CNT_W     (CNT_W)
            ) u_lane (
                .CLK     (CLK),
                .MR      (MR),
                .act     (act[i]),
                .cnt_clr (bus.CNT_CLR),
                .z       (z[i]),
                .rise    (rise[i]),
                .evt_cnt (evt[i])
            );
        end
    endgenerate

    assign bus.Z       = z;
    assign bus.RISE    = rise;
    assign bus.ANY     = |(z & ~bus.MASK);
    assign bus.EVT_CNT = evt;
endmodule

// File: tb/tb_sensor_array_filter.sv
module tb_sensor_array_filter;
    localparam int NCH = 4;
    localparam int DB  = 3;
    localparam int CW  = 8;
    localparam int NV  = 37;

    logic CLK = 1'b0;
    logic MR;
    always #5 CLK = ~CLK;

    sensor_array_filter_if #(.NCH(NCH), .CNT_W(CW)) bus ();
    sensor_array_filter #(.NCH(NCH), .DB_CYCLES(DB), .CNT_W(CW)) dut (
        .CLK (CLK), .MR (MR), .bus (bus)
    );

    // Second instance: single channel, DB_CYCLES=1, 2-bit counter for saturation.
    sensor_array_filter_if #(.NCH(1), .CNT_W(2)) bus2 ();
    sensor_array_filter #(.NCH(1), .DB_CYCLES(1), .CNT_W(2)) dut2 (
        .CLK (CLK), .MR (MR), .bus (bus2)
    );

    typedef struct {
        logic       mr;
        logic       pol;
        logic [3:0] mask;
        logic [3:0] x;
        logic [3:0] ez;
        logic [3:0] er;
        logic       ea;
    } vec_t;

    typedef struct {
        int          row;
        logic [3:0]  z;
        logic [3:0]  rise;
        logic        any;
        logic [31:0] cnt;
    } exp_t;

    vec_t tbl [NV];
    exp_t sb  [$];
    exp_t sb2 [$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   ecnt [NCH];

    task automatic chk(input string nm, input int row, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s row %0d: got %h want %h", nm, row, got, want);
        end
    endtask

    // DB_CYCLES=1 channel: push expectation, clock once, pop and compare.
    task automatic step2(input int row, input logic x, input logic clr,
                         input logic ez, input logic er, input int ec);
        exp_t e;
        exp_t g;
        e.row  = row;
        e.z    = {3'b0, ez};
        e.rise = {3'b0, er};
        e.any  = ez;
`ifdef SENSOR_EVENT_CNT_EN
        e.cnt  = 32'(ec);
`else
        e.cnt  = 32'(ec & 0);
`endif
        bus2.X       = x;
        bus2.CNT_CLR = clr;
        sb2.push_back(e);
        @(posedge CLK);
        #1;
        g = sb2.pop_front();
        chk("db1_z",    g.row, 32'(bus2.Z),       32'(g.z));
        chk("db1_rise", g.row, 32'(bus2.RISE),    32'(g.rise));
        chk("db1_any",  g.row, 32'(bus2.ANY),     32'(g.any));
        chk("db1_cnt",  g.row, 32'(bus2.EVT_CNT), g.cnt);
    endtask

    initial begin
        // mr, pol, mask, x, expected Z, RISE, ANY (POL=1: channel active when X bit is 0)
        tbl[0]  = '{1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0}; // reset
        tbl[1]  = '{1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 4'h0, 4'hF, 4'h0, 4'h0, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 4'h0, 4'hE, 4'h0, 4'h0, 1'b0}; // ch0 run
        tbl[4]  = '{1'b1, 1'b1, 4'h0, 4'hE, 4'h0, 4'h0, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 4'h0, 4'hE, 4'h1, 4'h1, 1'b1};
        tbl[6]  = '{1'b1, 1'b1, 4'h0, 4'hE, 4'h1, 4'h0, 1'b1};
        tbl[7]  = '{1'b1, 1'b1, 4'h0, 4'hC, 4'h1, 4'h0, 1'b1}; // ch1 2-edge glitch
        tbl[8]  = '{1'b1, 1'b1, 4'h0, 4'hC, 4'h1, 4'h0, 1'b1};
        tbl[9]  = '{1'b1, 1'b1, 4'h0, 4'hE, 4'h1, 4'h0, 1'b1};
        tbl[10] = '{1'b1, 1'b1, 4'h0, 4'hC, 4'h1, 4'h0, 1'b1}; // ch1 full run
        tbl[11] = '{1'b1, 1'b1, 4'h0, 4'hC, 4'h1, 4'h0, 1'b1};
        tbl[12] = '{1'b1, 1'b1, 4'h0, 4'hC, 4'h3, 4'h2, 1'b1};
        tbl[13] = '{1'b1, 1'b1, 4'h0, 4'h8, 4'h3, 4'h0, 1'b1}; // ch2 on
        tbl[14] = '{1'b1, 1'b1, 4'h0, 4'h8, 4'h3, 4'h0, 1'b1};
        tbl[15] = '{1'b1, 1'b1, 4'h0, 4'h8, 4'h7, 4'h4, 1'b1};
        tbl[16] = '{1'b1, 1'b1, 4'h0, 4'hC, 4'h7, 4'h0, 1'b1}; // ch2 2-edge release glitch
        tbl[17] = '{1'b1, 1'b1, 4'h0, 4'hC, 4'h7, 4'h0, 1'b1};
        tbl[18] = '{1'b1, 1'b1, 4'h0, 4'h8, 4'h7, 4'h0, 1'b1};
        tbl[19] = '{1'b1, 1'b1, 4'h0, 4'hC, 4'h7, 4'h0, 1'b1}; // ch2 full release
        tbl[20] = '{1'b1, 1'b1, 4'h0, 4'hC, 4'h7, 4'h0, 1'b1};
        tbl[21] = '{1'b1, 1'b1, 4'h0, 4'hC, 4'h3, 4'h0, 1'b1};
        tbl[22] = '{1'b1, 1'b1, 4'h1, 4'hE, 4'h3, 4'h0, 1'b1}; // mask ch0, release ch1
        tbl[23] = '{1'b1, 1'b1, 4'h1, 4'hE, 4'h3, 4'h0, 1'b1};
        tbl[24] = '{1'b1, 1'b1, 4'h1, 4'hE, 4'h1, 4'h0, 1'b0};
        tbl[25] = '{1'b1, 1'b1, 4'h1, 4'hA, 4'h1, 4'h0, 1'b0}; // ch2 on again
        tbl[26] = '{1'b1, 1'b1, 4'h1, 4'hA, 4'h1, 4'h0, 1'b0};
        tbl[27] = '{1'b1, 1'b1, 4'h1, 4'hA, 4'h5, 4'h4, 1'b1};
        tbl[28] = '{1'b1, 1'b1, 4'h1, 4'h2, 4'h5, 4'h0, 1'b1}; // ch3 pending
        tbl[29] = '{1'b1, 1'b1, 4'h1, 4'h2, 4'h5, 4'h0, 1'b1};
        tbl[30] = '{1'b0, 1'b1, 4'h1, 4'h2, 4'h0, 4'h0, 1'b0}; // reset mid-pend
        tbl[31] = '{1'b1, 1'b1, 4'h1, 4'h7, 4'h0, 4'h0, 1'b0}; // full run needed again
        tbl[32] = '{1'b1, 1'b1, 4'h1, 4'h7, 4'h0, 4'h0, 1'b0};
        tbl[33] = '{1'b1, 1'b1, 4'h1, 4'h7, 4'h8, 4'h8, 1'b1};
        tbl[34] = '{1'b1, 1'b0, 4'h1, 4'h7, 4'h8, 4'h0, 1'b1}; // flip polarity
        tbl[35] = '{1'b1, 1'b0, 4'h1, 4'h7, 4'h8, 4'h0, 1'b1};
        tbl[36] = '{1'b1, 1'b0, 4'h1, 4'h7, 4'h7, 4'h7, 1'b1}; // all channels switch at once

        bus.X = 4'h0;  bus.POL = 1'b1;  bus.MASK = 4'h0;  bus.CNT_CLR = 1'b0;
        bus2.X = 1'b1; bus2.POL = 1'b1; bus2.MASK = 1'b0; bus2.CNT_CLR = 1'b0;
        MR = 1'b0;
        for (int c = 0; c < NCH; c++) ecnt[c] = 0;

        for (int r = 0; r < NV; r++) begin
            exp_t e;
            exp_t g;
            MR       = tbl[r].mr;
            bus.POL  = tbl[r].pol;
            bus.MASK = tbl[r].mask;
            bus.X    = tbl[r].x;
            e.row  = r;
            e.z    = tbl[r].ez;
            e.rise = tbl[r].er;
            e.any  = tbl[r].ea;
            e.cnt  = '0;
            for (int c = 0; c < NCH; c++) begin
                if (!tbl[r].mr) ecnt[c] = 0;
                else if (tbl[r].er[c] && ecnt[c] < 255) ecnt[c]++;
`ifdef SENSOR_EVENT_CNT_EN
                e.cnt[c*CW +: CW] = CW'(ecnt[c]);
`endif
            end
            sb.push_back(e);
            @(posedge CLK);
            #1;
            g = sb.pop_front();
            chk("z",    g.row, 32'(bus.Z),    32'(g.z));
            chk("rise", g.row, 32'(bus.RISE), 32'(g.rise));
            chk("any",  g.row, 32'(bus.ANY),  32'(g.any));
            chk("cnt",  g.row, bus.EVT_CNT,   g.cnt);
        end

        // DB_CYCLES=1: Z is act delayed one cycle; 5 rises saturate a 2-bit counter.
        for (int n = 1; n <= 5; n++) begin
            step2(100 + 2*n, 1'b0, 1'b0, 1'b1, 1'b1, (n < 3) ? n : 3);
            step2(101 + 2*n, 1'b1, 1'b0, 1'b0, 1'b0, (n < 3) ? n : 3);
        end
        step2(120, 1'b0, 1'b1, 1'b1, 1'b1, 1); // clear coinciding with a rise
        step2(121, 1'b0, 1'b0, 1'b1, 1'b0, 1); // held active: no new event
        step2(122, 1'b1, 1'b1, 1'b0, 1'b0, 0); // plain clear, fall gives no RISE

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
